// File: rtl/s_u_restoring_div8.sv
// s_u_restoring_div8: sequential unsigned restoring divider, one quotient bit per clock
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid, in_ready, a, b  operand handshake; a is the 2N-bit dividend, b is the N-bit divisor
//   out_valid, out_ready      result handshake
//   quotient, remainder       floor(a/b) and a mod b, registered
//   div_by_zero               set with out_valid when the captured b was 0
module s_u_restoring_div8 #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);
    localparam int CW = $clog2(2 * N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [2*N-1:0] dvd;
    logic [N-1:0]   dvs;
    logic [CW-1:0]  cnt;
    logic [N:0]     r_sh;
    logic           ge;
    logic [N-1:0]   r_nx;
    // The partial remainder lives in the remainder register itself; the
    // N-bit subtraction is exact because the difference always fits in N bits.
    assign r_sh      = {remainder, dvd[2*N-1]};
    assign ge        = r_sh >= {1'b0, dvs};
    assign r_nx      = ge ? r_sh[N-1:0] - dvs : r_sh[N-1:0];
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (in_valid ? (b == '0 ? DONE : RUN) : IDLE) :
                   state == RUN  ? (cnt == CW'(2 * N - 1) ? DONE : RUN) :
                                   (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            quotient    <= b == '0 ? '1 : '0;
            remainder   <= '0;
            div_by_zero <= b == '0;
            dvd         <= a;
            dvs         <= b;
            cnt         <= '0;
        end else if (state == RUN) begin
            dvd       <= {dvd[2*N-2:0], 1'b0};
            remainder <= r_nx;
            quotient  <= {quotient[2*N-2:0], ge};
            cnt       <= cnt + 1'b1;
        end else if (state == DONE && out_ready) begin
            div_by_zero <= 1'b0;
        end
    end
endmodule

// File: tb/tb_s_u_restoring_div8.sv
// tb_s_u_restoring_div8: randomized self-checking bench with a behavioural divider model
module tb_s_u_restoring_div8;
    localparam int N = 4;
    typedef struct {
        logic [2*N-1:0] q;
        logic [N-1:0]   r;
        logic           dz;
        int             rdy;
    } exp_t;
    logic           clk = 0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mode = 0;
    bit armed = 0;
    exp_t exp_q[$];

    s_u_restoring_div8 #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an operation is in flight from its acceptance edge until the edge
    // that drains it; its result appears 2N edges after acceptance (0 for b=0).
    always @(negedge clk) begin : mon
        bit busy, ev;
        busy = exp_q.size() > 0;
        ev = busy && cyc >= exp_q[0].rdy;
        if (armed) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, !busy});
            chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
            if (ev) begin
                chk("quotient", 32'(quotient), 32'(exp_q[0].q));
                chk("remainder", 32'(remainder), 32'(exp_q[0].r));
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, exp_q[0].dz});
            end
        end
        out_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
        if (rst) exp_q.delete();
        else begin
            if (ev && out_ready) void'(exp_q.pop_front());
            if (in_valid && !busy)
                exp_q.push_back('{q: b == 0 ? 8'hFF : a / b, r: b == 0 ? 4'd0 : 4'(a % b),
                                  dz: b == 0, rdy: cyc + 1 + (b == 0 ? 0 : 2 * N)});
        end
    end

    task automatic op(input logic [2*N-1:0] av, input logic [N-1:0] bv, output int acc);
        bit got = 0;
        a = av;
        b = bv;
        in_valid = 1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            got = in_ready;
        end
        #2 in_valid = 0;
        acc = cyc;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_out(output int t);
        bit got = 0;
        t = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        if (got) t = cyc;
        else chk("result_timeout", 0, 1);
    endtask

    task automatic directed(input logic [2*N-1:0] av, input logic [N-1:0] bv, input int lat,
                            input logic [2*N-1:0] eq, input logic [N-1:0] er, input logic ed);
        int acc, t;
        op(av, bv, acc);
        wait_out(t);
        chk("latency", t - acc, lat);
        chk("lit_quotient", 32'(quotient), 32'(eq));
        chk("lit_remainder", 32'(remainder), 32'(er));
        chk("lit_div_by_zero", {31'b0, div_by_zero}, {31'b0, ed});
    endtask

    initial begin
        int acc;
        bit got;
        rst = 1;
        in_valid = 0;
        a = 0;
        b = 0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        armed = 1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_quotient", 32'(quotient), 0);
        chk("rst_remainder", 32'(remainder), 0);
        chk("rst_div_by_zero", {31'b0, div_by_zero}, 0);
        directed(200, 13, 8, 15, 5, 0);
        directed(255, 1, 8, 255, 0, 0);
        directed(7, 9, 8, 0, 7, 0);
        directed(0, 15, 8, 0, 0, 0);
        directed(100, 0, 0, 8'hFF, 0, 1);
        @(negedge clk);
        chk("dz_cleared", {31'b0, div_by_zero}, 0);
        chk("dz_idle", {31'b0, in_ready}, 1);
        mode = 2;
        directed(225, 15, 8, 15, 0, 0);
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", {31'b0, out_valid}, 1);
            chk("bp_quotient", 32'(quotient), 15);
            chk("bp_remainder", 32'(remainder), 0);
            chk("bp_in_ready", {31'b0, in_ready}, 0);
        end
        @(posedge clk);
        #2 mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_idle", {31'b0, in_ready}, 1);
        chk("bp_release_valid", {31'b0, out_valid}, 0);
        a = 200;
        b = 13;
        in_valid = 1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            got = in_ready;
        end
        repeat (4) @(posedge clk);
        #2 rst = 1;
        in_valid = 0;
        @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 1);
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_quotient", 32'(quotient), 0);
        directed(64, 8, 8, 8, 0, 0);
        mode = 1;
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 16; y++) op(8'(x), 4'(y), acc);
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2 op(8'($urandom), $urandom_range(0, 7) == 0 ? 4'd0 : 4'($urandom), acc);
        end
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = exp_q.size() == 0;
        end
        if (!got) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
